// File: rtl/ps2_keymatrix.sv
// rtl/ps2_keymatrix.sv - PS/2 set-2 scan-code decoder driving a 16-key hex matrix and a make/break event FIFO.
// Optional numpad mapping is enabled with the PS2_KEYMATRIX_NUMPAD_EN macro.
module ps2_keymatrix #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ps2_valid,
    input  logic [7:0]  ps2_data,
    output logic [15:0] keyMatrix,
    output logic        evt_valid,
    output logic [3:0]  evt_key,
    output logic        evt_down,
    input  logic        evt_pop,
    input  logic        flush,
    output logic        overflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BRK     = 3'd1,
        EXT     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    state_t       state, state_nx;
    logic [2:0]   skip_cnt, skip_nx;
    logic         map_hit;
    logic [3:0]   map_key;
    logic         do_make, do_break;
    logic         push_req, push_ok, pop_en;
    logic [15:0]  matrix_nx;

    logic [4:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]  count;

    always_comb begin
        map_hit = 1'b1;
        map_key = 4'h0;
        case (ps2_data)
            8'h16: map_key = 4'h1;
            8'h1E: map_key = 4'h2;
            8'h26: map_key = 4'h3;
            8'h25: map_key = 4'hC;
            8'h15: map_key = 4'h4;
            8'h1D: map_key = 4'h5;
            8'h24: map_key = 4'h6;
            8'h2D: map_key = 4'hD;
            8'h1C: map_key = 4'h7;
            8'h1B: map_key = 4'h8;
            8'h23: map_key = 4'h9;
            8'h2B: map_key = 4'hE;
            8'h1A: map_key = 4'hA;
            8'h22: map_key = 4'h0;
            8'h21: map_key = 4'hB;
            8'h2A: map_key = 4'hF;
`ifdef PS2_KEYMATRIX_NUMPAD_EN
            8'h70: map_key = 4'h0;
            8'h69: map_key = 4'h1;
            8'h72: map_key = 4'h2;
            8'h7A: map_key = 4'h3;
            8'h6B: map_key = 4'h4;
            8'h73: map_key = 4'h5;
            8'h74: map_key = 4'h6;
            8'h6C: map_key = 4'h7;
            8'h75: map_key = 4'h8;
            8'h7D: map_key = 4'h9;
`endif
            default: map_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        do_make  = 1'b0;
        do_break = 1'b0;
        if (ps2_valid) begin
            case (state)
                IDLE: begin
                    if (ps2_data == 8'hF0)      state_nx = BRK;
                    else if (ps2_data == 8'hE0) state_nx = EXT;
                    else if (ps2_data == 8'hE1) begin
                        state_nx = PAUSE;
                        skip_nx  = 3'd7;
                    end else begin
                        do_make = map_hit;
                    end
                end
                BRK: begin
                    do_break = map_hit;
                    state_nx = IDLE;
                end
                EXT:     state_nx = (ps2_data == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: state_nx = IDLE;
                PAUSE: begin
                    // Pause is a fixed 8-byte sequence; the E1 already consumed one.
                    skip_nx = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        state_nx = IDLE;
                        skip_nx  = 3'd0;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        push_req  = (do_make & ~keyMatrix[map_key]) | (do_break & keyMatrix[map_key]);
        matrix_nx = keyMatrix;
        if (push_req) matrix_nx[map_key] = do_make;
        pop_en  = evt_pop && (count != '0);
        push_ok = push_req && ((count != DEPTH_C) || pop_en);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            skip_cnt  <= 3'd0;
            keyMatrix <= 16'h0000;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nx;
            skip_cnt  <= skip_nx;
            keyMatrix <= matrix_nx;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
                if (push_ok && !pop_en)      count <= count + 1'b1;
                else if (!push_ok && pop_en) count <= count - 1'b1;
                if (push_req && !push_ok) overflow <= 1'b1;
            end
        end
    end

    // When full with a pop, the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (!res && !flush && push_ok) mem[wr_ptr] <= {map_key, do_make};
    end

    assign evt_valid = (count != '0);
    assign evt_key   = evt_valid ? mem[rd_ptr][4:1] : 4'h0;
    assign evt_down  = evt_valid ? mem[rd_ptr][0]   : 1'b0;

endmodule
